// File: rtl/branch_predictor_pkg.sv
// Shared types and default geometry for the fetch-side branch predictor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The 2-bit counter encoding is the usual bimodal scheme. Its MSB is the
// predicted direction. The predicted-taken bit travels with the instruction
// in flags[16] and comes back as upd_pred_taken when the branch resolves.
package branch_predictor_pkg;

  localparam int BP_IDX_BITS = 6;   // 64-entry direct-mapped table
  localparam int BP_TAG_BITS = 8;
  localparam int BP_CNT_W    = 16;  // mispredict counter width

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,   // strongly not taken
    CTR_WNT = 2'd1,   // weakly not taken (reset value)
    CTR_WT  = 2'd2,   // weakly taken (fresh allocation)
    CTR_ST  = 2'd3    // strongly taken
  } bp_ctr_e;

endpackage

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating up/down counter step used when training a table entry.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   ctr     in  2  current counter value
//   taken   in  1  resolved outcome: 1 = count up, 0 = count down
//   ctr_nxt out 2  next counter value, clamped to [CTR_SNT, CTR_ST]
module bp_sat_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal predictor with BTB. Gives a taken/target prediction
// per fetch PC and is trained by branches that resolve in EX.
// Latency: 0-cycle lookup. 2-stage update (capture, then apply) with forwarding.
// Backpressure: none. Lookups and updates are accepted every cycle.
//
// Ports:
//   clk, nreset     clock (rising edge) and async active-low reset
//   if_valid/if_pc  fetch lookup request
//   pred_taken      predicted taken, combinational from table/stage
//   pred_target     {target,2'b00} when predicted taken, else next sequential PC
//   upd_*           resolved conditional branch: pc, outcome, carried prediction, target
//   bp_clear        synchronous invalidate of every entry and of the update stage
//   mispred_count   saturating count of resolved mispredictions
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int TAG_BITS = BP_TAG_BITS,
  parameter int CNT_W    = BP_CNT_W
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_target,
  input  logic             bp_clear,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Table state. The valid bit of every entry is cleared by the async reset,
  // so the table is built from flops rather than a RAM macro.
  logic [ENTRIES-1:0] tbl_valid;
  logic [TAG_BITS-1:0] tbl_tag [ENTRIES];
  logic [29:0]         tbl_tgt [ENTRIES];
  logic [1:0]          tbl_ctr [ENTRIES];

  // Update stage: an entry computed at capture, written at the next edge.
  // A stage entry is always valid when s_valid is set.
  logic                s_valid;
  logic [IDX_BITS-1:0] s_idx;
  logic [TAG_BITS-1:0] s_tag;
  logic [29:0]         s_tgt;
  logic [1:0]          s_ctr;

  // ---------------- lookup ----------------
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag_in;
  logic                lk_fwd, lk_valid, lk_hit;
  logic [TAG_BITS-1:0] lk_tag;
  logic [29:0]         lk_tgt;
  logic [1:0]          lk_ctr;

  assign lk_idx    = if_pc[IDX_BITS+1:2];
  assign lk_tag_in = if_pc[IDX_BITS+2 +: TAG_BITS];

  // A pending stage entry for the same index is newer than the table copy.
  assign lk_fwd   = s_valid && (s_idx == lk_idx);
  assign lk_valid = lk_fwd ? 1'b1  : tbl_valid[lk_idx];
  assign lk_tag   = lk_fwd ? s_tag : tbl_tag[lk_idx];
  assign lk_tgt   = lk_fwd ? s_tgt : tbl_tgt[lk_idx];
  assign lk_ctr   = lk_fwd ? s_ctr : tbl_ctr[lk_idx];
  assign lk_hit   = lk_valid && (lk_tag == lk_tag_in);

  assign pred_taken  = if_valid && lk_hit && lk_ctr[1];
  // Sequential path wraps naturally at the top of the address space.
  assign pred_target = pred_taken ? {lk_tgt, 2'b00} : {if_pc[31:2] + 30'd1, 2'b00};

  // ---------------- capture ----------------
  logic [IDX_BITS-1:0] cap_idx;
  logic [TAG_BITS-1:0] cap_tag_in;
  logic                cap_fwd, cap_valid, cap_hit, cap_write;
  logic [TAG_BITS-1:0] cap_tag;
  logic [1:0]          cap_ctr, cap_ctr_nxt, cap_ctr_new;

  assign cap_idx    = upd_pc[IDX_BITS+1:2];
  assign cap_tag_in = upd_pc[IDX_BITS+2 +: TAG_BITS];

  // Forwarding here lets back-to-back updates to one index compound.
  assign cap_fwd   = s_valid && (s_idx == cap_idx);
  assign cap_valid = cap_fwd ? 1'b1  : tbl_valid[cap_idx];
  assign cap_tag   = cap_fwd ? s_tag : tbl_tag[cap_idx];
  assign cap_ctr   = cap_fwd ? s_ctr : tbl_ctr[cap_idx];
  assign cap_hit   = cap_valid && (cap_tag == cap_tag_in);

  bp_sat_ctr2 u_sat_ctr (
    .ctr     (cap_ctr),
    .taken   (upd_taken),
    .ctr_nxt (cap_ctr_nxt)
  );

  // A not-taken miss is not worth allocating.
  assign cap_write   = upd_valid && (cap_hit || upd_taken);
  assign cap_ctr_new = cap_hit ? cap_ctr_nxt : CTR_WT;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s_valid <= 1'b0;
      s_idx   <= '0;
      s_tag   <= '0;
      s_tgt   <= '0;
      s_ctr   <= CTR_WNT;
    end else begin
      // A clear in the same cycle wins over the capture.
      s_valid <= cap_write && !bp_clear;
      if (cap_write) begin
        s_idx <= cap_idx;
        s_tag <= cap_tag_in;
        s_tgt <= upd_target[31:2];
        s_ctr <= cap_ctr_new;
      end
    end
  end

  // ---------------- apply ----------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tbl_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_tag[i] <= '0;
        tbl_tgt[i] <= '0;
        tbl_ctr[i] <= CTR_WNT;
      end
    end else if (bp_clear) begin
      // Counters, tags and targets keep their values. They are masked by valid=0.
      tbl_valid <= '0;
    end else if (s_valid) begin
      tbl_valid[s_idx] <= 1'b1;
      tbl_tag[s_idx]   <= s_tag;
      tbl_tgt[s_idx]   <= s_tgt;
      tbl_ctr[s_idx]   <= s_ctr;
    end
  end

  // ---------------- mispredict counter ----------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mispred_count <= '0;
    end else if (upd_valid && (upd_taken ^ upd_pred_taken) && (mispred_count != '1)) begin
      mispred_count <= mispred_count + 1'b1;
    end
  end

  // Address bits outside the index/tag/target fields carry no information here.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_pc[31:IDX_BITS+2+TAG_BITS],
                         upd_target[1:0]};

endmodule
